// File: rtl/wsched_pkg.sv
// Shared types and constants for the wash scheduler.
package wsched_pkg;

  // Per-machine slot state
  typedef enum logic [1:0] {
    StIdle,
    StStart,
    StRun,
    StFault
  } slot_state_e;

  // Completion status codes reported back to the requester
  localparam logic [1:0] ST_OK   = 2'b00;
  localparam logic [1:0] ST_INTR = 2'b01;
  localparam logic [1:0] ST_TMO  = 2'b10;

  // Index width with a floor of one bit
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/wash_slot_fsm.sv
// One machine slot: start pulse, double-wash hold, watchdog, owner tracking and
// completion reporting for a single washing machine.
module wash_slot_fsm
  import wsched_pkg::*;
#(
  parameter int unsigned TIMEOUT = 64,
  parameter int unsigned OwnerW  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              grant_i,
  input  logic [OwnerW-1:0] owner_i,
  input  logic              dwash_i,
  input  logic              done_i,
  input  logic              intr_i,
  input  logic              clr_fault_i,
  output logic              start_o,
  output logic              dwash_o,
  output logic              idle_o,
  output logic              fault_o,
  output logic              busy_o,
  output logic              cmpl_o,
  output logic [1:0]        status_o,
  output logic [OwnerW-1:0] owner_o
);

  localparam int unsigned TmrW = $clog2(TIMEOUT + 1);
  localparam logic [TmrW-1:0] TmrLast = TmrW'(TIMEOUT - 1);
  localparam logic [TmrW-1:0] TmrMax  = {TmrW{1'b1}};

  slot_state_e       state_q, state_d;
  logic [TmrW-1:0]   timer_q, timer_d;
  logic [OwnerW-1:0] owner_q, owner_d;
  logic              dwash_q, dwash_d;
  logic              start_q, start_d;
  logic              cmpl_q, cmpl_d;
  logic [1:0]        status_q, status_d;

  // Next-state: grant capture, start pulse, run supervision, fault recovery
  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    owner_d  = owner_q;
    dwash_d  = dwash_q;
    start_d  = 1'b0;
    cmpl_d   = 1'b0;
    status_d = ST_OK;
    unique case (state_q)
      StIdle: begin
        if (grant_i) begin
          state_d = StStart;
          owner_d = owner_i;
          dwash_d = dwash_i;
        end
      end
      StStart: begin
        state_d = StRun;
        start_d = 1'b1;
        timer_d = '0;
      end
      StRun: begin
        // Interrupt outranks done when both arrive together
        if (intr_i) begin
          state_d  = StIdle;
          cmpl_d   = 1'b1;
          status_d = ST_INTR;
          dwash_d  = 1'b0;
        end else if (done_i) begin
          state_d  = StIdle;
          cmpl_d   = 1'b1;
          status_d = ST_OK;
          dwash_d  = 1'b0;
        end else if (timer_q == TmrLast) begin
          state_d  = StFault;
          cmpl_d   = 1'b1;
          status_d = ST_TMO;
          dwash_d  = 1'b0;
        end else if (timer_q != TmrMax) begin
          timer_d = timer_q + TmrW'(1);
        end
      end
      StFault: begin
        if (clr_fault_i) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Slot state registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      timer_q  <= '0;
      owner_q  <= '0;
      dwash_q  <= 1'b0;
      start_q  <= 1'b0;
      cmpl_q   <= 1'b0;
      status_q <= ST_OK;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      owner_q  <= owner_d;
      dwash_q  <= dwash_d;
      start_q  <= start_d;
      cmpl_q   <= cmpl_d;
      status_q <= status_d;
    end
  end

  assign start_o  = start_q;
  assign dwash_o  = dwash_q;
  assign idle_o   = (state_q == StIdle);
  assign fault_o  = (state_q == StFault);
  assign busy_o   = (state_q == StStart) || (state_q == StRun);
  assign cmpl_o   = cmpl_q;
  assign status_o = status_q;
  assign owner_o  = owner_q;

endmodule

// File: rtl/wash_scheduler.sv
// Wash scheduler top: request capture, round-robin arbitration onto idle machines
// and per-requester completion merge.
// Build option: define WSCHED_PRIORITY_EN to give requester 0 strict priority.
module wash_scheduler
  import wsched_pkg::*;
#(
  parameter int unsigned NUM_REQ  = 4,
  parameter int unsigned NUM_MACH = 2,
  parameter int unsigned TIMEOUT  = 64
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic [NUM_REQ-1:0]                            req_i,
  input  logic [NUM_REQ-1:0]                            dwash_req_i,
  output logic [NUM_REQ-1:0]                            busy_o,
  output logic [NUM_REQ-1:0]                            grant_o,
  output logic [((NUM_MACH > 1) ? $clog2(NUM_MACH) : 1)-1:0] grant_mach_o,
  output logic [NUM_REQ-1:0]                            cmpl_o,
  output logic [2*NUM_REQ-1:0]                          cmpl_status_o,
  output logic [NUM_MACH-1:0]                           start_o,
  output logic [NUM_MACH-1:0]                           dwash_o,
  input  logic [NUM_MACH-1:0]                           done_i,
  input  logic [NUM_MACH-1:0]                           intr_i,
  input  logic [NUM_MACH-1:0]                           clr_fault_i,
  output logic [NUM_MACH-1:0]                           fault_o,
  output logic [NUM_MACH-1:0]                           idle_o
);

  localparam int unsigned RW = idx_w(NUM_REQ);
  localparam int unsigned MW = idx_w(NUM_MACH);

  logic [NUM_REQ-1:0] pend_q, pend_d;
  logic [NUM_REQ-1:0] dlat_q, dlat_d;
  logic [RW-1:0]      rr_ptr_q, rr_ptr_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [MW-1:0]      grant_mach_q, grant_mach_d;

  logic [NUM_REQ-1:0]  cap;
  logic [NUM_REQ-1:0]  gnt_vec;
  logic                gnt_valid;
  logic                req_found;
  logic                prio_hit;
  logic [RW-1:0]       req_sel;
  logic [RW:0]         idx_sum;
  logic                any_idle;
  logic [MW-1:0]       mach_sel;

  logic [NUM_MACH-1:0] slot_grant;
  logic [NUM_MACH-1:0] slot_busy;
  logic [NUM_MACH-1:0] slot_cmpl;
  logic [1:0]          slot_status [NUM_MACH];
  logic [RW-1:0]       slot_owner  [NUM_MACH];

  // Pick lowest idle machine and next pending requester from rr_ptr
  always_comb begin
    any_idle  = 1'b0;
    mach_sel  = '0;
    req_found = 1'b0;
    req_sel   = '0;
    idx_sum   = '0;
    prio_hit  = 1'b0;
    for (int m = NUM_MACH - 1; m >= 0; m--) begin
      if (idle_o[m]) begin
        any_idle = 1'b1;
        mach_sel = MW'(m);
      end
    end
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      idx_sum = {1'b0, rr_ptr_q} + (RW + 1)'(i);
      if (idx_sum >= (RW + 1)'(NUM_REQ)) idx_sum = idx_sum - (RW + 1)'(NUM_REQ);
      if (!req_found && pend_q[idx_sum[RW-1:0]]) begin
        req_found = 1'b1;
        req_sel   = idx_sum[RW-1:0];
      end
    end
`ifdef WSCHED_PRIORITY_EN
    if (pend_q[0]) begin
      req_found = 1'b1;
      req_sel   = '0;
      prio_hit  = 1'b1;
    end
`endif
    gnt_valid = req_found && any_idle;
    for (int unsigned r = 0; r < NUM_REQ; r++) begin
      gnt_vec[r] = gnt_valid && (req_sel == RW'(r));
    end
    for (int unsigned m = 0; m < NUM_MACH; m++) begin
      slot_grant[m] = gnt_valid && (mach_sel == MW'(m));
    end
  end

  // Request capture, pending/option latches, pointer advance and grant pulse
  always_comb begin
    cap          = req_i & ~busy_o;
    pend_d       = (pend_q | cap) & ~gnt_vec;
    dlat_d       = (dlat_q & ~cap) | (dwash_req_i & cap);
    rr_ptr_d     = rr_ptr_q;
    grant_d      = gnt_vec;
    grant_mach_d = gnt_valid ? mach_sel : '0;
    if (gnt_valid && !prio_hit) begin
      rr_ptr_d = (req_sel == RW'(NUM_REQ - 1)) ? '0 : req_sel + RW'(1);
    end
  end

  // Arbiter registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_q       <= '0;
      dlat_q       <= '0;
      rr_ptr_q     <= '0;
      grant_q      <= '0;
      grant_mach_q <= '0;
    end else begin
      pend_q       <= pend_d;
      dlat_q       <= dlat_d;
      rr_ptr_q     <= rr_ptr_d;
      grant_q      <= grant_d;
      grant_mach_q <= grant_mach_d;
    end
  end

  for (genvar m = 0; m < NUM_MACH; m++) begin : g_slot
    wash_slot_fsm #(
      .TIMEOUT (TIMEOUT),
      .OwnerW  (RW)
    ) u_slot (
      .clk         (clk),
      .rst         (rst),
      .grant_i     (slot_grant[m]),
      .owner_i     (req_sel),
      .dwash_i     (dlat_q[req_sel]),
      .done_i      (done_i[m]),
      .intr_i      (intr_i[m]),
      .clr_fault_i (clr_fault_i[m]),
      .start_o     (start_o[m]),
      .dwash_o     (dwash_o[m]),
      .idle_o      (idle_o[m]),
      .fault_o     (fault_o[m]),
      .busy_o      (slot_busy[m]),
      .cmpl_o      (slot_cmpl[m]),
      .status_o    (slot_status[m]),
      .owner_o     (slot_owner[m])
    );
  end

  // Route slot completions and in-service flags to their owning requesters
  always_comb begin
    cmpl_o        = '0;
    cmpl_status_o = '0;
    busy_o        = pend_q;
    for (int unsigned m = 0; m < NUM_MACH; m++) begin
      for (int unsigned r = 0; r < NUM_REQ; r++) begin
        if (slot_owner[m] == RW'(r)) begin
          if (slot_cmpl[m]) begin
            cmpl_o[r]              = 1'b1;
            cmpl_status_o[2*r +: 2] = slot_status[m];
          end
          if (slot_busy[m]) busy_o[r] = 1'b1;
        end
      end
    end
  end

  assign grant_o      = grant_q;
  assign grant_mach_o = grant_mach_q;

endmodule

// File: tb/tb_wash_scheduler.sv
// Directed bench for wash_scheduler (NUM_REQ=4, NUM_MACH=2, TIMEOUT=64).
module tb_wash_scheduler;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req_i, dwash_req_i;
  logic [3:0] busy_o, grant_o, cmpl_o;
  logic       grant_mach_o;
  logic [7:0] cmpl_status_o;
  logic [1:0] start_o, dwash_o, done_i, intr_i, clr_fault_i, fault_o, idle_o;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  wash_scheduler #(
    .NUM_REQ  (4),
    .NUM_MACH (2),
    .TIMEOUT  (64)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .req_i         (req_i),
    .dwash_req_i   (dwash_req_i),
    .busy_o        (busy_o),
    .grant_o       (grant_o),
    .grant_mach_o  (grant_mach_o),
    .cmpl_o        (cmpl_o),
    .cmpl_status_o (cmpl_status_o),
    .start_o       (start_o),
    .dwash_o       (dwash_o),
    .done_i        (done_i),
    .intr_i        (intr_i),
    .clr_fault_i   (clr_fault_i),
    .fault_o       (fault_o),
    .idle_o        (idle_o)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp)
    else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; req_i = '0; dwash_req_i = '0;
    done_i = '0; intr_i = '0; clr_fault_i = '0;
    #3;
    check("rst_idle", 32'(idle_o), 'b11);
    check("rst_busy", 32'(busy_o), 0);
    check("rst_grant", 32'(grant_o), 0);
    check("rst_gmach", 32'(grant_mach_o), 0);
    check("rst_start", 32'(start_o), 0);
    check("rst_dwash", 32'(dwash_o), 0);
    check("rst_fault", 32'(fault_o), 0);
    check("rst_cmpl", 32'(cmpl_o), 0);
    check("rst_status", 32'(cmpl_status_o), 0);
    tick(); rst = 1'b0; tick();

    // Single job, requester 1, double wash, finished by done
    req_i = 'b0010; dwash_req_i = 'b0010;
    tick(); req_i = '0; dwash_req_i = '0;
    check("sj_busy", 32'(busy_o), 'b0010);
    check("sj_nogrant", 32'(grant_o), 0);
    tick();
    check("sj_grant", 32'(grant_o), 'b0010);
    check("sj_gmach", 32'(grant_mach_o), 0);
    check("sj_dwash", 32'(dwash_o), 'b01);
    check("sj_idle", 32'(idle_o), 'b10);
    check("sj_nostart", 32'(start_o), 0);
    tick();
    check("sj_start", 32'(start_o), 'b01);
    check("sj_grant_off", 32'(grant_o), 0);
    repeat (19) tick();
    done_i = 'b01;
    tick(); done_i = '0;
    check("sj_cmpl", 32'(cmpl_o), 'b0010);
    check("sj_status", 32'(cmpl_status_o), 0);
    check("sj_busy_clr", 32'(busy_o), 0);
    check("sj_idle_back", 32'(idle_o), 'b11);
    check("sj_dwash_clr", 32'(dwash_o), 0);
    tick();
    check("sj_cmpl_pulse", 32'(cmpl_o), 0);

    // Round-robin from a fresh pointer
    rst = 1'b1; #1; rst = 1'b0;
    req_i = 'b1111;
    tick(); req_i = '0;
    check("rr_busy", 32'(busy_o), 'b1111);
    tick();
    check("rr_g0", 32'(grant_o), 'b0001);
    check("rr_g0m", 32'(grant_mach_o), 0);
    tick();
    check("rr_g1", 32'(grant_o), 'b0010);
    check("rr_g1m", 32'(grant_mach_o), 1);
    tick();
    check("rr_nogrant", 32'(grant_o), 0);
    check("rr_start1", 32'(start_o), 'b10);
    check("rr_allbusy", 32'(idle_o), 0);
    done_i = 'b01;
    tick(); done_i = '0;
    check("rr_c0", 32'(cmpl_o), 'b0001);
    tick();
    check("rr_g2", 32'(grant_o), 'b0100);
    check("rr_g2m", 32'(grant_mach_o), 0);
    done_i = 'b10;
    tick(); done_i = '0;
    check("rr_c1", 32'(cmpl_o), 'b0010);
    check("rr_gap", 32'(grant_o), 0);
    tick();
    check("rr_g3", 32'(grant_o), 'b1000);
    check("rr_g3m", 32'(grant_mach_o), 1);
    req_i = 'b0011;
    tick(); req_i = '0;
    check("rr_busy2", 32'(busy_o), 'b1111);
    check("rr_wait", 32'(grant_o), 0);
    done_i = 'b01;
    tick(); done_i = '0;
    check("rr_c2", 32'(cmpl_o), 'b0100);
    tick();
    check("rr_wrap", 32'(grant_o), 'b0001);
    tick();
    check("to_start0", 32'(start_o), 'b01);

    // Interrupt and done together on machine 1 (owner 3)
    done_i = 'b10; intr_i = 'b10;
    tick(); done_i = '0; intr_i = '0;
    check("ir_cmpl", 32'(cmpl_o), 'b1000);
    check("ir_status", 32'(cmpl_status_o), 'h40);
    check("ir_idle", 32'(idle_o), 'b10);
    tick();
    check("ir_regrant", 32'(grant_o), 'b0010);
    check("ir_regrant_m", 32'(grant_mach_o), 1);
    tick();
    check("ir_start1", 32'(start_o), 'b10);
    done_i = 'b10;
    tick(); done_i = '0;
    check("ir_c1", 32'(cmpl_o), 'b0010);

    // Watchdog on machine 0: started 4 cycles ago
    repeat (58) tick();
    tick();
    check("to_edge_cmpl", 32'(cmpl_o), 0);
    check("to_edge_fault", 32'(fault_o), 0);
    tick();
    check("to_cmpl", 32'(cmpl_o), 'b0001);
    check("to_status", 32'(cmpl_status_o), 'h02);
    check("to_fault", 32'(fault_o), 'b01);
    check("to_idle", 32'(idle_o), 'b10);
    check("to_busy", 32'(busy_o), 0);

    // Faulted machine skipped; done ignored in FAULT; clear; re-request ignored
    req_i = 'b0100;
    tick(); req_i = '0;
    check("fs_busy", 32'(busy_o), 'b0100);
    done_i = 'b01;
    tick(); done_i = '0;
    check("fs_grant", 32'(grant_o), 'b0100);
    check("fs_gmach", 32'(grant_mach_o), 1);
    check("fs_fault_hold", 32'(fault_o), 'b01);
    check("fs_nocmpl", 32'(cmpl_o), 0);
    tick();
    req_i = 'b0100; clr_fault_i = 'b01;
    tick(); req_i = '0; clr_fault_i = '0;
    check("fs_clr_idle", 32'(idle_o), 'b01);
    check("fs_clr_fault", 32'(fault_o), 0);
    check("fs_busy2", 32'(busy_o), 'b0100);
    tick();
    check("fs_no_regrant", 32'(grant_o), 0);
    done_i = 'b10;
    tick(); done_i = '0;
    check("fs_cmpl", 32'(cmpl_o), 'b0100);
    tick();
    check("fs_one_cmpl", 32'(cmpl_o), 0);
    check("fs_no_job", 32'(grant_o), 0);
    check("fs_busy_clr", 32'(busy_o), 0);

    // Requesters 0 and 3 pending together with rr_ptr at 3
    req_i = 'b0110;
    tick(); req_i = '0;
    tick();
    check("pr_g1", 32'(grant_o), 'b0010);
    tick();
    check("pr_g2", 32'(grant_o), 'b0100);
    req_i = 'b1001;
    tick(); req_i = '0;
    check("pr_busy", 32'(busy_o), 'b1111);
    done_i = 'b01;
    tick(); done_i = '0;
    check("pr_c1", 32'(cmpl_o), 'b0010);
    tick();
`ifdef WSCHED_PRIORITY_EN
    check("pr_winner", 32'(grant_o), 'b0001);
`else
    check("pr_winner", 32'(grant_o), 'b1000);
`endif
    check("pr_wmach", 32'(grant_mach_o), 0);

    // Asynchronous reset mid-job
    #3; rst = 1'b1; #1;
    check("ar_idle", 32'(idle_o), 'b11);
    check("ar_busy", 32'(busy_o), 0);
    check("ar_grant", 32'(grant_o), 0);
    check("ar_start", 32'(start_o), 0);
    check("ar_dwash", 32'(dwash_o), 0);
    check("ar_cmpl", 32'(cmpl_o), 0);
    tick(); rst = 1'b0; done_i = 'b11;
    tick(); done_i = '0;
    check("ar_no_cmpl", 32'(cmpl_o), 0);
    check("ar_idle2", 32'(idle_o), 'b11);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/wash_scheduler.md
Name: wash_scheduler

Overview:
Shares a pool of NUM_MACH washing_machine_fsm instances between NUM_REQ customer requesters (coin stations).
- Queues requests and arbitrates them round-robin onto idle machines.
- Issues each machine's coin/start pulse and double-wash select.
- Supervises every job with a watchdog and reports completion status back to the requester that owns the job.

Parameters:
- NUM_REQ, 4, number of requesters (min 2)
- NUM_MACH, 2, number of machines (min 1)
- TIMEOUT, 64, max cycles from start pulse to done/interrupt before the machine is faulted (min 2)

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous reset, active-high
- req_i  in  NUM_REQ  one-cycle request pulse per requester
- dwash_req_i  in  NUM_REQ  double-wash option, sampled with req_i
- busy_o  out  NUM_REQ  requester has a pending or in-service job
- grant_o  out  NUM_REQ  one-cycle pulse when the request is assigned to a machine
- grant_mach_o  out  $clog2(NUM_MACH) (min 1)  machine index, valid with grant_o
- cmpl_o  out  NUM_REQ  one-cycle job-complete pulse
- cmpl_status_o  out  2*NUM_REQ  per requester: 00 ok, 01 interrupted, 10 timeout; valid with cmpl_o
- start_o  out  NUM_MACH  one-cycle start pulse to the machine's coin_deposit_i
- dwash_o  out  NUM_MACH  double-wash select; held for the whole job
- done_i  in  NUM_MACH  machine done_o
- intr_i  in  NUM_MACH  machine off_interrupt_o
- clr_fault_i  in  NUM_MACH  returns a faulted machine to service
- fault_o  out  NUM_MACH  machine out of service
- idle_o  out  NUM_MACH  machine available for grant

Behaviour:
- Reset (rst=1, asynchronous):
  - all outputs 0 except idle_o = all 1s
  - pending bits, owners and timers cleared
  - round-robin pointer = requester 0
- Request capture:
  - req_i[r] while busy_o[r]=0 sets pend[r] and latches dwash_req_i[r]; busy_o[r] rises the next cycle.
  - req_i[r] while busy_o[r]=1 is ignored.
- Arbitration:
  - At most one grant per cycle.
  - The requester is the first pending index at or after rr_ptr, cyclic.
  - The machine is the lowest-index machine in IDLE.
  - On a grant: pend[r] clears, grant_o[r]=1, owner[m]=r, rr_ptr = r+1 mod NUM_REQ.
  - With no idle machine, requests stay pending; no starvation.
- Per-machine FSM states: IDLE, START, RUN, FAULT.
  - IDLE -> START on grant; dwash_o[m] is driven from the latched option.
  - START: start_o[m]=1 for exactly one cycle, timer=0, then RUN.
    - Grant-to-start latency is 1 cycle.
  - RUN: the timer increments each cycle; transitions are evaluated in priority order:
    - intr_i -> IDLE, status 01
    - else done_i -> IDLE, status 00
    - else timer == TIMEOUT-1 -> FAULT, status 10
    - intr_i and done_i in the same cycle resolve to interrupted.
  - Completion (any of the three exits): cmpl_o[owner] pulses in the same cycle the exit condition is sampled (registered, visible the next cycle); busy_o[owner] clears with it.
  - Leaving RUN clears dwash_o[m].
  - FAULT: fault_o[m]=1, idle_o[m]=0; clr_fault_i[m] -> IDLE the next cycle. clr_fault_i has no effect in other states.
  - done_i/intr_i are ignored in IDLE, START and FAULT.
- A machine that goes IDLE via done or interrupt may be granted again in the following cycle.
- Several machines may complete in the same cycle; owners are distinct, so the per-requester cmpl_o bits are independent.
- A requester may re-request in the cycle after its cmpl_o pulse.
- Timer width: $clog2(TIMEOUT+1); it saturates and never wraps.
- Reset mid-job aborts everything with no cmpl_o pulse.

Optional Feature:
- WSCHED_PRIORITY_EN
  - Defined: requester 0 has strict priority. When pend[0] is set it wins the grant regardless of rr_ptr, and rr_ptr is not updated.
  - Requesters 1..NUM_REQ-1 use round-robin among themselves.
  - Undefined: pure round-robin over all requesters, as specified above.

Decomposition:
- wsched_pkg holds:
  - slot state enum: IDLE, START, RUN, FAULT
  - status constants: ST_OK=2'b00, ST_INTR=2'b01, ST_TMO=2'b10
- Sub-module wash_slot_fsm, instantiated once per machine:
  - contains the state, timer, owner register, dwash_o, start_o and fault handling
  - takes grant/owner/dwash in; gives cmpl/status/owner out
- The top level holds request capture, arbitration and the per-requester cmpl/status merge.

Test Plan:
- Single job: req_i[1]=1 with dwash_req_i[1]=1, both machines idle -> grant_o[1] and grant_mach_o=0; start_o[0] pulses the next cycle with dwash_o[0]=1; done_i[0] 20 cycles later -> cmpl_o[1]=1, status 00, busy_o[1]=0.
- Round-robin: req_i=4'b1111 in one cycle with NUM_MACH=2 -> grant order 0,1 on consecutive cycles; after the machines finish, grants go to 2 then 3; rr_ptr then wraps to 0.
- Interrupt priority: in RUN, assert done_i[1] and intr_i[1] in the same cycle -> status 01 to the owner; machine 1 returns to IDLE.
- Timeout: no done for 64 cycles -> cmpl status 10, fault_o[0]=1, and machine 0 is skipped by grants; clr_fault_i[0] -> idle_o[0]=1 the next cycle.
- Ignored re-request: req_i[2] pulsed twice while busy -> only one grant and one cmpl; with WSCHED_PRIORITY_EN and pend set for requesters 0 and 3, requester 0 is granted first.
- Async reset in RUN: assert rst mid-job -> all outputs 0 and idle_o all 1s immediately, no cmpl_o pulse.
